// File: rtl/delim_frame_pkg.sv
// delim_frame_pkg: shared types and constants for the "100"-delimited serial framing (rev 1.0).
// Frame length grows by two bits when DELIM_FRAME_TX_PARITY_EN is defined.
`default_nettype none

package delim_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELIM = 3'd1,
    ST_DATA  = 3'd2,
    ST_STUFF = 3'd3,
    ST_GAP   = 3'd4
`ifdef DELIM_FRAME_TX_PARITY_EN
    ,
    ST_PARITY = 3'd5
`endif
  } state_t;

  localparam logic       IDLE_LEVEL = 1'b1;
  localparam logic [2:0] DELIM      = 3'b100;
  localparam int         DELIM_LEN  = 3;

  // Worst case is a stuff bit after every other payload bit.
  function automatic int max_frame_len(input int data_w);
    int len;
    len = DELIM_LEN + data_w + (data_w + 1) / 2;
`ifdef DELIM_FRAME_TX_PARITY_EN
    len = len + 2;
`endif
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/delim_frame_tx_if.sv
// delim_frame_tx_if: producer-side start/ready handshake plus the serial line outputs (rev 1.0).
`default_nettype none

interface delim_frame_tx_if #(
  parameter int DATA_W = 8
) ();

  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              w;
  logic              done;

  modport master (
    output start,
    output data_in,
    input  ready,
    input  w,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output ready,
    output w,
    output done
  );

endinterface

`default_nettype wire

// File: rtl/delim_frame_tx_stuffer.sv
// frame_stuffer: two-bit history of transmitted payload bits; requests a stuff 1 after "10" (rev 1.0).
`default_nettype none

module frame_stuffer (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clr,
  input  wire logic push,
  input  wire logic bit_in,
  output logic      stuff_req
);

  logic [1:0] hist;

  // A clear together with a push starts the history from "00" and records the new bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b00;
    end else if (push) begin
      hist <= {(clr ? 1'b0 : hist[0]), bit_in};
    end else if (clr) begin
      hist <= 2'b00;
    end
  end

  assign stuff_req = (hist == 2'b10);

endmodule

`default_nettype wire

// File: rtl/delim_frame_tx.sv
// delim_frame_tx: sends 1,0,0 then a bit-stuffed MSB-first payload on w; idle line is 1 (rev 1.0).
// Option DELIM_FRAME_TX_PARITY_EN appends a stuffed even-parity bit after the payload.
`default_nettype none

module delim_frame_tx
  import delim_frame_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input wire logic         clk,
  input wire logic         rst,
  delim_frame_tx_if.slave  bus
);

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  state_t                 state;
  logic [DATA_W-1:0]      data_lat;
  logic [CW-1:0]          bit_cnt;
  logic [CW-1:0]          next_idx;
  logic [DELIM_LEN-1:0]   delim_sh;
  logic [1:0]             delim_left;
  logic                   w_reg;
  logic                   ready_reg;
  logic                   done_reg;

  logic                   stuff_req;
  logic                   hist_clr;
  logic                   hist_push;
  logic                   emit_stuff;
  logic                   emit_data;
  logic                   next_bit;
`ifdef DELIM_FRAME_TX_PARITY_EN
  logic                   par_sent;
  logic                   emit_par;
`endif

  // Decide which payload-region bit goes onto w at the coming edge.
  always_comb begin
    emit_stuff = 1'b0;
    emit_data  = 1'b0;
    hist_clr   = 1'b0;
    next_bit   = IDLE_LEVEL;
    next_idx   = bit_cnt - 1'b1;
`ifdef DELIM_FRAME_TX_PARITY_EN
    emit_par   = 1'b0;
`endif
    case (state)
      ST_DELIM: begin
        if (delim_left == 2'd0) begin
          hist_clr = 1'b1;
          next_bit = data_lat[bit_cnt];
        end
      end
      ST_DATA, ST_STUFF
`ifdef DELIM_FRAME_TX_PARITY_EN
      , ST_PARITY
`endif
      : begin
        if (stuff_req) begin
          emit_stuff = 1'b1;
          next_bit   = 1'b1;
        end else if (bit_cnt != '0) begin
          emit_data = 1'b1;
          next_bit  = data_lat[next_idx];
        end
`ifdef DELIM_FRAME_TX_PARITY_EN
        else if (!par_sent) begin
          emit_par = 1'b1;
          next_bit = ^data_lat;
        end
`endif
      end
      default: ;
    endcase
  end

`ifdef DELIM_FRAME_TX_PARITY_EN
  assign hist_push = hist_clr | emit_stuff | emit_data | emit_par;
`else
  assign hist_push = hist_clr | emit_stuff | emit_data;
`endif

  frame_stuffer u_stuffer (
    .clk       (clk),
    .rst       (rst),
    .clr       (hist_clr),
    .push      (hist_push),
    .bit_in    (next_bit),
    .stuff_req (stuff_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      data_lat   <= '0;
      bit_cnt    <= '0;
      delim_sh   <= '0;
      delim_left <= 2'd0;
      w_reg      <= IDLE_LEVEL;
      ready_reg  <= 1'b1;
      done_reg   <= 1'b0;
`ifdef DELIM_FRAME_TX_PARITY_EN
      par_sent   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state)
        ST_IDLE: begin
          w_reg <= IDLE_LEVEL;
          if (bus.start) begin
            data_lat   <= bus.data_in;
            bit_cnt    <= CW'(DATA_W - 1);
            delim_sh   <= DELIM << 1;
            delim_left <= 2'(DELIM_LEN - 1);
            w_reg      <= DELIM[DELIM_LEN-1];
            ready_reg  <= 1'b0;
            state      <= ST_DELIM;
`ifdef DELIM_FRAME_TX_PARITY_EN
            par_sent   <= 1'b0;
`endif
          end
        end
        ST_DELIM: begin
          if (delim_left == 2'd0) begin
            w_reg <= next_bit;
            state <= ST_DATA;
          end else begin
            w_reg      <= delim_sh[DELIM_LEN-1];
            delim_sh   <= delim_sh << 1;
            delim_left <= delim_left - 2'd1;
          end
        end
        ST_DATA, ST_STUFF
`ifdef DELIM_FRAME_TX_PARITY_EN
        , ST_PARITY
`endif
        : begin
          w_reg <= next_bit;
          if (emit_stuff) begin
            state <= ST_STUFF;
          end else if (emit_data) begin
            state   <= ST_DATA;
            bit_cnt <= next_idx;
          end
`ifdef DELIM_FRAME_TX_PARITY_EN
          else if (emit_par) begin
            state    <= ST_PARITY;
            par_sent <= 1'b1;
          end
`endif
          else begin
            state    <= ST_GAP;
            done_reg <= 1'b1;
          end
        end
        ST_GAP: begin
          w_reg     <= IDLE_LEVEL;
          ready_reg <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          w_reg     <= IDLE_LEVEL;
          ready_reg <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.w     = w_reg;
  assign bus.ready = ready_reg;
  assign bus.done  = done_reg;

endmodule

`default_nettype wire

// File: doc/delim_frame_tx.md
Name: delim_frame_tx

Overview:
Serial frame transmitter that drives the single-bit line `w` consumed by the team's "100" pattern detector.
- Each frame starts with the delimiter 1,0,0.
- The payload follows MSB first, with bit-stuffing so that "100" never appears outside the delimiter.
- The idle line is held at 1.
- Sits between a parallel producer (start/ready handshake) and the serial link.

Parameters:
DATA_W, 8, payload width in bits (>= 2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset; synchronous and active-high
start  in  1  request to send data_in; accepted only when ready=1
data_in  in  DATA_W  payload, captured on the acceptance edge
ready  out  1  1 = idle and able to accept start
w  out  1  registered serial line output
done  out  1  one-cycle pulse after the last frame bit

Behaviour:
- Reset: synchronous, active-high. On the rst edge: state=IDLE, w=1, ready=1, done=0, stuff history cleared. A frame in progress is abandoned with no done pulse.
- States: IDLE, DELIM, DATA, STUFF, GAP (plus PARITY under option).
- IDLE:
  - w=1, ready=1.
  - start&ready at edge k: latch data_in, bit counter=DATA_W-1, enter DELIM.
  - start while ready=0 is ignored.
- Timing: frame bit i is on w during cycle k+1+i. The first bit is delimiter bit 1, which is indistinguishable from idle.
- DELIM:
  - Drives 1,0,0 over 3 cycles, then DATA.
  - Stuff history is reset to "00" at the delimiter end, so the payload starts clean.
- Stuffing rule (payload region only):
  - Track the last two transmitted bits, stuff bits included.
  - Whenever the last two are "1","0", the next cycle drives a stuff bit 1 (STUFF state). The data bit is not consumed.
  - The rule applies after the final payload bit too: a frame whose payload ends in "10" still emits a trailing stuff 1.
- DATA: drives the current bit and decrements the counter. After bit 0, go to GAP (or STUFF first if the rule fires; STUFF then goes to GAP).
- GAP:
  - One cycle, w=1, done=1, ready=0.
  - Then IDLE, so there is a guaranteed minimum of one idle 1 between frames.
- Frame length: 3 + DATA_W + (number of stuff bits). Maximum is 3 + DATA_W + ceil(DATA_W/2), plus 2 with the parity option.
- Invariants:
  - w is always registered; no combinational path from start to w.
  - Outside the delimiter the stream never contains "100".

Optional Feature:
Macro DELIM_FRAME_TX_PARITY_EN.
- Defined:
  - After the last payload bit (and any stuff bit), a PARITY state sends the even parity of the DATA_W data bits. Stuff bits are excluded from the parity.
  - The parity bit is itself subject to the stuffing rule, then GAP.
- Undefined: DATA (or STUFF) goes directly to GAP; no parity logic is synthesized.

Decomposition:
- Shared package `delim_frame_pkg`, which the detector side also imports:
  - State enum.
  - IDLE_LEVEL=1'b1.
  - DELIM=3'b100 and DELIM_LEN=3.
  - Function max_frame_len(DATA_W).
- One natural sub-module: `frame_stuffer`, which holds the 2-bit history register and the stuff-request logic, with a clear-history input for the delimiter end.

Test Plan:
1. Reset, hold start=0 for 10 cycles -> w=1, ready=1, done=0 throughout.
2. data_in=8'hA5, start pulse -> w = 1,0,0, 1,0,1,1,0,1,0,1,1,0,1,1 (15 bits), then GAP with done=1, then ready=1. With the parity option, 0 then stuff 1 are inserted before GAP (17 bits).
3. data_in=8'h00 -> 1,0,0, 0,0,0,0,0,0,0,0 (11 bits, no stuffing); then 8'hFF -> 1,0,0 followed by eight 1s.
4. Assert start every cycle -> exactly one frame is accepted per IDLE period. There is at least one w=1 GAP cycle between frames, and data_in changes during a frame are not transmitted.
5. rst=1 at frame bit 6 of 8'hA5 -> the next cycle has w=1, ready=1, done never pulses; a new frame with 8'h3C transmits correctly.
6. Random data, 1000 frames, scoreboard -> no "100" outside delimiters; destuffed payload equals data_in.
